// File: rtl/sram_like_arbiter.sv
// N-master to 1-slave arbiter for the SRAM-like req/addr_ok/data_ok bus.
// In-order ID FIFO routes each data_ok back to its issuing master.
module sram_like_arbiter #(
   parameter int N_MST    = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_OUT  = 4,
   parameter int ARB_MODE = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_MST-1:0]             m_req,
   input  logic [N_MST-1:0]             m_wr,
   input  logic [2*N_MST-1:0]           m_size,
   input  logic [(DATA_W/8)*N_MST-1:0]  m_wstrb,
   input  logic [ADDR_W*N_MST-1:0]      m_addr,
   input  logic [DATA_W*N_MST-1:0]      m_wdata,
   output logic [N_MST-1:0]             m_addr_ok,
   output logic [N_MST-1:0]             m_data_ok,
   output logic [DATA_W-1:0]            m_rdata,
   output logic                         s_req,
   output logic                         s_wr,
   output logic [1:0]                   s_size,
   output logic [DATA_W/8-1:0]          s_wstrb,
   output logic [ADDR_W-1:0]            s_addr,
   output logic [DATA_W-1:0]            s_wdata,
   input  logic                         s_addr_ok,
   input  logic                         s_data_ok,
   input  logic [DATA_W-1:0]            s_rdata,
   output logic                         err
);

   localparam int ID_W  = (N_MST > 1) ? $clog2(N_MST) : 1;
   localparam int PTR_W = $clog2(MAX_OUT);
   localparam int CNT_W = PTR_W + 1;
   localparam int SW    = DATA_W / 8;

   logic [ID_W-1:0]  fifo [MAX_OUT];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  locked_id;
   logic [ID_W-1:0]  grant;
   logic [ID_W-1:0]  rr_next;
   logic [ID_W-1:0]  head_id;
   logic             lock;
   logic             full;
   logic             req_g;
   logic             hs;
   logic             pop;
   logic             found;

   // A stalled request keeps its grant until the slave accepts it.
   always_comb begin
      grant = '0;
      found = 1'b0;
      if (lock) begin
         grant = locked_id;
      end else if (ARB_MODE == 0) begin
         for (int i = N_MST - 1; i >= 0; i--) begin
            if (m_req[i]) grant = ID_W'(i);
         end
      end else begin
         for (int k = 0; k < N_MST; k++) begin
            if (!found && m_req[(int'(rr_ptr) + k) % N_MST]) begin
               grant = ID_W'((int'(rr_ptr) + k) % N_MST);
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      req_g   = 1'b0;
      s_wr    = 1'b0;
      s_size  = '0;
      s_wstrb = '0;
      s_addr  = '0;
      s_wdata = '0;
      for (int i = 0; i < N_MST; i++) begin
         if (grant == ID_W'(i)) begin
            req_g   = m_req[i];
            s_wr    = m_wr[i];
            s_size  = m_size[2*i +: 2];
            s_wstrb = m_wstrb[SW*i +: SW];
            s_addr  = m_addr[ADDR_W*i +: ADDR_W];
            s_wdata = m_wdata[DATA_W*i +: DATA_W];
         end
      end
   end

   assign full    = (count == CNT_W'(MAX_OUT));
   assign s_req   = req_g & ~full & ~reset;
   assign hs      = s_req & s_addr_ok;
   assign head_id = fifo[rd_ptr];
   assign pop     = s_data_ok & (count != '0) & ~reset;
   assign m_rdata = s_rdata;
   assign rr_next = (grant == ID_W'(N_MST - 1)) ? '0 : grant + ID_W'(1);

   always_comb begin
      m_addr_ok = '0;
      m_data_ok = '0;
      for (int i = 0; i < N_MST; i++) begin
         m_addr_ok[i] = hs & (grant == ID_W'(i));
         m_data_ok[i] = pop & (head_id == ID_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (hs) fifo[wr_ptr] <= grant;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         rr_ptr    <= '0;
         lock      <= 1'b0;
         locked_id <= '0;
         err       <= 1'b0;
      end else begin
         if (hs) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            lock   <= 1'b0;
            if (ARB_MODE == 1) rr_ptr <= rr_next;
         end else if (s_req) begin
            lock      <= 1'b1;
            locked_id <= grant;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         // A response with nothing outstanding is a slave protocol error.
         if (s_data_ok && count == '0) err <= 1'b1;
         count <= count + CNT_W'(hs) - CNT_W'(pop);
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: fixed-priority 2-master instance driven from a vector
// table, plus a 3-master round-robin instance.
module tb_sram_like_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Fixed-priority instance
   logic        rst0;
   logic [1:0]  req0;
   logic [1:0]  wr0    = 2'b10;
   logic [3:0]  size0  = {2'd2, 2'd1};
   logic [7:0]  wstrb0 = {4'hF, 4'h3};
   logic [63:0] addr0  = {32'h2000_0010, 32'h1000_0000};
   logic [63:0] wdata0 = {32'hBBBB_0001, 32'hAAAA_0000};
   logic [1:0]  addr_ok0, data_ok0;
   logic [31:0] rdata0, srdata0;
   logic        sreq0, swr0, saok0, sdok0, err0;
   logic [1:0]  ssize0;
   logic [3:0]  swstrb0;
   logic [31:0] saddr0, swdata0;

   sram_like_arbiter #(
      .N_MST(2), .ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .ARB_MODE(0)
   ) u_fp (
      .clk(clk), .reset(rst0),
      .m_req(req0), .m_wr(wr0), .m_size(size0), .m_wstrb(wstrb0),
      .m_addr(addr0), .m_wdata(wdata0),
      .m_addr_ok(addr_ok0), .m_data_ok(data_ok0), .m_rdata(rdata0),
      .s_req(sreq0), .s_wr(swr0), .s_size(ssize0), .s_wstrb(swstrb0),
      .s_addr(saddr0), .s_wdata(swdata0),
      .s_addr_ok(saok0), .s_data_ok(sdok0), .s_rdata(srdata0),
      .err(err0)
   );

   // Round-robin instance
   logic        rst1;
   logic [2:0]  req1;
   logic [2:0]  wr1    = 3'b000;
   logic [5:0]  size1  = 6'h2A;
   logic [11:0] wstrb1 = 12'hFFF;
   logic [95:0] addr1  = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
   logic [95:0] wdata1 = '0;
   logic [2:0]  addr_ok1, data_ok1;
   logic [31:0] rdata1;
   logic [31:0] srdata1 = 32'h0;
   logic        sreq1, swr1, saok1, err1;
   logic        sdok1 = 1'b0;
   logic [1:0]  ssize1;
   logic [3:0]  swstrb1;
   logic [31:0] saddr1, swdata1;

   sram_like_arbiter #(
      .N_MST(3), .ADDR_W(32), .DATA_W(32), .MAX_OUT(8), .ARB_MODE(1)
   ) u_rr (
      .clk(clk), .reset(rst1),
      .m_req(req1), .m_wr(wr1), .m_size(size1), .m_wstrb(wstrb1),
      .m_addr(addr1), .m_wdata(wdata1),
      .m_addr_ok(addr_ok1), .m_data_ok(data_ok1), .m_rdata(rdata1),
      .s_req(sreq1), .s_wr(swr1), .s_size(ssize1), .s_wstrb(swstrb1),
      .s_addr(saddr1), .s_wdata(swdata1),
      .s_addr_ok(saok1), .s_data_ok(sdok1), .s_rdata(srdata1),
      .err(err1)
   );

   typedef struct {
      bit       rst;
      bit [1:0] req;
      bit       aok;
      bit       dok;
      bit       sreq;
      bit [1:0] ao;
      bit [1:0] dk;
      bit       err;
      bit       sel;
   } vec_t;

   function automatic vec_t mk(bit rst, bit [1:0] req, bit aok, bit dok,
                               bit sreq, bit [1:0] ao, bit [1:0] dk,
                               bit err, bit sel);
      vec_t v;
      v.rst = rst; v.req = req; v.aok = aok; v.dok = dok;
      v.sreq = sreq; v.ao = ao; v.dk = dk; v.err = err; v.sel = sel;
      return v;
   endfunction

   function automatic logic [70:0] mux_exp(bit sel);
      if (sel)
         return {1'b1, 2'd2, 4'hF, 32'h2000_0010, 32'hBBBB_0001};
      return {1'b0, 2'd1, 4'h3, 32'h1000_0000, 32'hAAAA_0000};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic run0(input string tag, input vec_t v);
      logic [70:0] got;
      @(negedge clk);
      rst0 = v.rst; req0 = v.req; saok0 = v.aok; sdok0 = v.dok;
      srdata0 = $urandom;
      #2;
      chk({tag, " s_req"}, 128'(sreq0), 128'(v.sreq));
      chk({tag, " m_addr_ok"}, 128'(addr_ok0), 128'(v.ao));
      chk({tag, " m_data_ok"}, 128'(data_ok0), 128'(v.dk));
      chk({tag, " err"}, 128'(err0), 128'(v.err));
      chk({tag, " m_rdata"}, 128'(rdata0), 128'(srdata0));
      got = {swr0, ssize0, swstrb0, saddr0, swdata0};
      if (v.sreq) chk({tag, " mux"}, 128'(got), 128'(mux_exp(v.sel)));
   endtask

   task automatic run1(input string tag, input bit [2:0] req,
                       input bit [2:0] exp_ao);
      @(negedge clk);
      rst1 = 1'b0; req1 = req; saok1 = 1'b1;
      #2;
      chk({tag, " rr m_addr_ok"}, 128'(addr_ok1), 128'(exp_ao));
   endtask

   vec_t tv [30];

   initial begin
      rst0 = 1'b1; req0 = '0; saok0 = 1'b0; sdok0 = 1'b0; srdata0 = '0;
      rst1 = 1'b1; req1 = '0; saok1 = 1'b0;

      //            rst req aok dok | sreq ao    dk    err sel
      tv[0]  = mk(1, 2'b11, 1, 0,  0, 2'b00, 2'b00, 0, 0);
      tv[1]  = mk(0, 2'b11, 1, 0,  1, 2'b01, 2'b00, 0, 0);
      tv[2]  = mk(0, 2'b11, 1, 0,  1, 2'b01, 2'b00, 0, 0);
      tv[3]  = mk(0, 2'b10, 1, 1,  1, 2'b10, 2'b01, 0, 1);
      tv[4]  = mk(0, 2'b00, 1, 1,  0, 2'b00, 2'b01, 0, 0);
      tv[5]  = mk(0, 2'b00, 1, 1,  0, 2'b00, 2'b10, 0, 0);
      tv[6]  = mk(0, 2'b01, 1, 0,  1, 2'b01, 2'b00, 0, 0);
      tv[7]  = mk(0, 2'b01, 1, 0,  1, 2'b01, 2'b00, 0, 0);
      tv[8]  = mk(0, 2'b01, 1, 0,  1, 2'b01, 2'b00, 0, 0);
      tv[9]  = mk(0, 2'b01, 1, 0,  1, 2'b01, 2'b00, 0, 0);
      tv[10] = mk(0, 2'b01, 1, 0,  0, 2'b00, 2'b00, 0, 0);
      tv[11] = mk(0, 2'b01, 1, 1,  0, 2'b00, 2'b01, 0, 0);
      tv[12] = mk(0, 2'b01, 1, 0,  1, 2'b01, 2'b00, 0, 0);
      tv[13] = mk(0, 2'b00, 1, 1,  0, 2'b00, 2'b01, 0, 0);
      tv[14] = mk(0, 2'b00, 1, 1,  0, 2'b00, 2'b01, 0, 0);
      tv[15] = mk(0, 2'b00, 1, 1,  0, 2'b00, 2'b01, 0, 0);
      tv[16] = mk(0, 2'b00, 1, 1,  0, 2'b00, 2'b01, 0, 0);
      tv[17] = mk(0, 2'b10, 1, 0,  1, 2'b10, 2'b00, 0, 1);
      tv[18] = mk(0, 2'b01, 1, 0,  1, 2'b01, 2'b00, 0, 0);
      tv[19] = mk(0, 2'b10, 1, 0,  1, 2'b10, 2'b00, 0, 1);
      tv[20] = mk(0, 2'b01, 1, 1,  1, 2'b01, 2'b10, 0, 0);
      tv[21] = mk(0, 2'b00, 0, 1,  0, 2'b00, 2'b01, 0, 0);
      tv[22] = mk(0, 2'b00, 0, 1,  0, 2'b00, 2'b10, 0, 0);
      tv[23] = mk(0, 2'b00, 0, 1,  0, 2'b00, 2'b01, 0, 0);
      tv[24] = mk(0, 2'b00, 0, 1,  0, 2'b00, 2'b00, 0, 0);
      tv[25] = mk(0, 2'b01, 1, 0,  1, 2'b01, 2'b00, 1, 0);
      tv[26] = mk(1, 2'b11, 1, 0,  0, 2'b00, 2'b00, 1, 0);
      tv[27] = mk(0, 2'b00, 0, 1,  0, 2'b00, 2'b00, 0, 0);
      tv[28] = mk(0, 2'b00, 0, 0,  0, 2'b00, 2'b00, 1, 0);
      tv[29] = mk(1, 2'b00, 0, 0,  0, 2'b00, 2'b00, 1, 0);

      @(posedge clk);
      for (int i = 0; i < 30; i++)
         run0($sformatf("row%0d", i), tv[i]);

      // Master 1 stalls; master 0 arriving later must not steal the grant.
      run0("lock1", mk(0, 2'b10, 0, 0, 1, 2'b00, 2'b00, 0, 1));
      run0("lock2", mk(0, 2'b11, 0, 0, 1, 2'b00, 2'b00, 0, 1));
      run0("lock3", mk(0, 2'b11, 0, 0, 1, 2'b00, 2'b00, 0, 1));
      run0("lock4", mk(0, 2'b11, 1, 0, 1, 2'b10, 2'b00, 0, 1));
      run0("lock5", mk(0, 2'b01, 1, 0, 1, 2'b01, 2'b00, 0, 0));
      run0("lock6", mk(0, 2'b00, 0, 1, 0, 2'b00, 2'b10, 0, 0));
      run0("lock7", mk(0, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 0));

      run1("rr0", 3'b111, 3'b001);
      run1("rr1", 3'b111, 3'b010);
      run1("rr2", 3'b111, 3'b100);
      run1("rr3", 3'b111, 3'b001);
      run1("rr4", 3'b111, 3'b010);
      run1("rr5", 3'b111, 3'b100);
      run1("rr6", 3'b110, 3'b010);
      run1("rr7", 3'b011, 3'b001);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the SRAM-like req/addr_ok/data_ok interface used by the CPU's inst and data ports.
- Lets several requesters share one SRAM-like slave port, e.g. inst + data into a single AXI bridge, or future cache/uncached paths.
- Tracks outstanding transactions in an in-order ID FIFO and routes each data_ok/rdata response back to the master that issued the request.
- Supports fixed-priority and round-robin arbitration.

Parameters:
- N_MST, 2, number of master channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- MAX_OUT, 4, maximum outstanding accepted-but-unanswered transactions (power of 2, ≥2).
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (lower index wins); 1 = round-robin.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m_req  in  N_MST  per-master request
- m_wr  in  N_MST  per-master write flag
- m_size  in  2*N_MST  per-master size, master i at [2i+1:2i]
- m_wstrb  in  (DATA_W/8)*N_MST  per-master byte strobes
- m_addr  in  ADDR_W*N_MST  per-master addresses
- m_wdata  in  DATA_W*N_MST  per-master write data
- m_addr_ok  out  N_MST  per-master address accepted
- m_data_ok  out  N_MST  per-master response valid
- m_rdata  out  DATA_W  shared read data, broadcast to all masters
- s_req  out  1  slave request
- s_wr  out  1  slave write flag
- s_size  out  2  slave size
- s_wstrb  out  DATA_W/8  slave byte strobes
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_addr_ok  in  1  slave address accepted
- s_data_ok  in  1  slave response valid
- s_rdata  in  DATA_W  slave read data
- err  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset state: ID FIFO empty (rd_ptr = wr_ptr = count = 0), rr_ptr = 0, lock = 0, err = 0.
  - While reset is high, s_req, all m_addr_ok and all m_data_ok are 0.
- Full: full = (count == MAX_OUT). While full, s_req = 0 and m_addr_ok = 0, regardless of a same-cycle pop.
- Grant:
  - If lock = 1, grant = locked_id.
  - Otherwise, in mode 0, grant = lowest i with m_req[i].
  - In mode 1, grant = first i with m_req[i], searching from rr_ptr upward with wrap modulo N_MST.
- Slave request: s_req = m_req[grant] & !full & !reset.
  - s_wr, s_size, s_wstrb, s_addr and s_wdata are muxed combinationally from the granted master; values are don't-care when s_req = 0.
- Address handshake: the handshake occurs when s_req & s_addr_ok. In that cycle:
  - m_addr_ok[grant] = 1; all other m_addr_ok bits are 0.
  - grant ID is pushed to FIFO[wr_ptr].
  - wr_ptr increments and wraps at MAX_OUT.
  - lock clears.
  - In mode 1, rr_ptr <= (grant + 1) mod N_MST.
- Grant lock: if s_req = 1 and s_addr_ok = 0, lock <= 1 and locked_id <= grant.
  - Grant and the muxed request fields stay on that master until the handshake. A higher-priority arrival must not steal the grant.
  - The master is required to hold req until addr_ok, as elsewhere in the CPU.
- Response:
  - m_rdata = s_rdata at all times.
  - On s_data_ok with count > 0: m_data_ok[FIFO[rd_ptr]] = 1 (combinational, same cycle), rd_ptr increments with wrap.
  - Responses return strictly in issue order.
- Simultaneous push and pop in one cycle: count is unchanged; both pointers advance.
- Protocol error: s_data_ok with count == 0 sets err <= 1 (sticky until reset). No m_data_ok is raised and the pointers do not move.
- Latency: zero added cycles on both paths; every output is a combinational function of inputs and registered state.
- Reset mid-operation: FIFO contents are discarded. A late s_data_ok after reset is treated as a protocol error, setting err. Clearing the slave is the owner's responsibility.
- Width rules: ID width = clog2(N_MST), minimum 1; count width = clog2(MAX_OUT) + 1.

Test Plan:
- N_MST=2, ARB_MODE=0; m_req=2'b11, s_addr_ok=1 every cycle, s_data_ok returned 2 cycles later -> master 0 granted in every cycle in which it requests. When master 0 drops req, master 1 gets the next handshake. Each data_ok goes to its issuer in order, and m_rdata equals s_rdata.
- ARB_MODE=1, N_MST=3; all m_req held high, s_addr_ok=1 -> grant sequence 0,1,2,0,1,2.
- Master 1 requests with s_addr_ok held 0 for 3 cycles while master 0 rises in cycle 2 -> s_addr stays m_addr[1] throughout. The handshake on cycle 4 acks master 1 and pushes ID 1; master 0 is granted next.
- MAX_OUT=4; 4 handshakes with no s_data_ok -> s_req=0 and m_addr_ok=0 while requests are pending. In the cycle s_data_ok pops, s_req is still 0; the next cycle s_req=1 and the stalled request proceeds.
- Issue with IDs 1,0,1 outstanding, then s_data_ok on one cycle concurrent with a new handshake from master 0 -> m_data_ok=2'b10 and the pushed ID is 0. count stays 3, and later responses route 0,1,0.
- s_data_ok pulse with FIFO empty -> err rises next cycle and m_data_ok stays 0. Then assert reset for 1 cycle -> err=0, count=0, s_req=0 during reset.
